// File: rtl/graph_mem_loader_pkg.sv
// -----------------------------------------------------------------------------
// graph_mem_pkg
// Shared constants for the Graph Memory writer: address/width constants, the
// layout of header, index and adjacency words, the loader state encoding, and
// a helper that drops one (V,W) pair into a 128-bit adjacency record.
// -----------------------------------------------------------------------------
package graph_mem_pkg;

    localparam int ADDR_W    = 13;
    localparam int NODE_W    = 8;
    localparam int MAX_LINKS = 7;
    localparam int REC_W     = 128;

    localparam logic [ADDR_W-1:0] HDR_ADDR = 13'h0000;
    localparam logic [ADDR_W-1:0] ADJ_BASE = 13'h0400;

    // Adjacency record: link count field
    localparam int CNT_HI  = 119;
    localparam int CNT_LO  = 112;
    // Index word: next-node field and record pointer
    localparam int NEXT_HI = 71;
    localparam int NEXT_LO = 64;
    localparam int PTR_HI  = 12;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WR_ADJ  = 3'd2,
        S_WR_IDX  = 3'd3,
        S_FILL    = 3'd4,
        S_WR_HDR  = 3'd5,
        S_DONE    = 3'd6
    } state_e;

    // Pair k (1..MAX_LINKS): V at [127-16k -: 8], W at [119-16k -: 8]
    function automatic logic [REC_W-1:0] pack_pair(
        input logic [REC_W-1:0]  rec,
        input int                k,
        input logic [NODE_W-1:0] v,
        input logic [NODE_W-1:0] w
    );
        logic [REC_W-1:0] r;
        r = rec;
        r[(127 - 16*k) -: 8] = v;
        r[(119 - 16*k) -: 8] = w;
        return r;
    endfunction

endpackage

// File: rtl/graph_mem_loader_adj_packer.sv
// -----------------------------------------------------------------------------
// adj_packer
// Collects the (V,W) pairs of the current source node and presents them as a
// ready-to-write 128-bit adjacency record.
// Optional feature (macro MIN_MERGE_EN): a pushed dst already present keeps its
// slot and the stored weight becomes the signed minimum of old and new.
// Ports:
//   clock, reset   system clock, async active-low reset
//   i_clr          clear all pairs and the link count
//   i_push         store (or merge) i_dst/i_wt
//   o_record       packed adjacency record (count + pairs)
//   o_full         MAX_LINKS pairs already stored
//   o_dup          i_dst matches a stored pair (always 0 without MIN_MERGE_EN)
// -----------------------------------------------------------------------------
module adj_packer
    import graph_mem_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              i_clr,
    input  logic              i_push,
    input  logic [NODE_W-1:0] i_dst,
    input  logic [NODE_W-1:0] i_wt,
    output logic [REC_W-1:0]  o_record,
    output logic              o_full,
    output logic              o_dup
);

    logic [NODE_W-1:0]  r_v [1:MAX_LINKS];
    logic [NODE_W-1:0]  r_w [1:MAX_LINKS];
    logic [NODE_W-1:0]  r_count;
    logic [MAX_LINKS:1] w_match;
    logic [REC_W-1:0]   w_rec;

    // Slot match of the incoming dst against the stored pairs
    always_comb begin
        w_match = '0;
`ifdef MIN_MERGE_EN
        for (int k = 1; k <= MAX_LINKS; k++) begin
            w_match[k] = (r_count >= NODE_W'(k)) && (r_v[k] == i_dst);
        end
`endif
    end

    assign o_dup  = |w_match;
    assign o_full = (r_count == NODE_W'(MAX_LINKS));

    // Pair storage: clear, merge into a matching slot, or append
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            for (int k = 1; k <= MAX_LINKS; k++) begin
                r_v[k] <= '0;
                r_w[k] <= '0;
            end
        end else if (i_clr) begin
            r_count <= '0;
            for (int k = 1; k <= MAX_LINKS; k++) begin
                r_v[k] <= '0;
                r_w[k] <= '0;
            end
        end else if (i_push) begin
            if (o_dup) begin
                for (int k = 1; k <= MAX_LINKS; k++) begin
                    if (w_match[k] && ($signed(i_wt) < $signed(r_w[k]))) begin
                        r_w[k] <= i_wt;
                    end
                end
            end else if (!o_full) begin
                for (int k = 1; k <= MAX_LINKS; k++) begin
                    if (r_count == NODE_W'(k - 1)) begin
                        r_v[k] <= i_dst;
                        r_w[k] <= i_wt;
                    end
                end
                r_count <= r_count + 8'd1;
            end
        end
    end

    // Record image; cleared slots give zero pairs for the unused positions
    always_comb begin
        w_rec = '0;
        w_rec[CNT_HI:CNT_LO] = r_count;
        for (int k = 1; k <= MAX_LINKS; k++) begin
            w_rec = pack_pair(w_rec, k, r_v[k], r_w[k]);
        end
    end

    assign o_record = w_rec;

endmodule

// File: rtl/graph_mem_loader.sv
// -----------------------------------------------------------------------------
// graph_mem_loader
// Writer side of Graph Memory. Consumes an edge stream sorted by source node
// and writes, for every node 1..N, an adjacency record followed by an index
// word, then the header at address 0 (2N+1 writes in total).
// Optional feature: MIN_MERGE_EN (duplicate dst min-merge inside adj_packer).
// Ports:
//   clock, reset            system clock, async active-low reset
//   start, num_nodes        load request (sampled only in IDLE) and node count
//   edge_valid/ready        edge handshake; edge_src/dst/wt/last beat fields
//   GMWAR/GMWDR/GMWE        registered Graph Memory write port
//   busy, done              load in progress / one-cycle completion pulse
//   err_overflow/order/range sticky drop flags, cleared by reset or start
// -----------------------------------------------------------------------------
module graph_mem_loader
    import graph_mem_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [NODE_W-1:0] num_nodes,
    input  logic              edge_valid,
    output logic              edge_ready,
    input  logic [NODE_W-1:0] edge_src,
    input  logic [NODE_W-1:0] edge_dst,
    input  logic [NODE_W-1:0] edge_wt,
    input  logic              edge_last,
    output logic [ADDR_W-1:0] GMWAR,
    output logic [REC_W-1:0]  GMWDR,
    output logic              GMWE,
    output logic              busy,
    output logic              done,
    output logic              err_overflow,
    output logic              err_order,
    output logic              err_range
);

    state_e             r_state, w_state_next;
    logic [NODE_W-1:0]  r_cur, r_n;
    logic               r_tail;
    logic               r_err_ovf, r_err_ord, r_err_rng;
    logic               r_gmwe, r_busy, r_done;
    logic [ADDR_W-1:0]  r_gmwar;
    logic [REC_W-1:0]   r_gmwdr;

    logic               w_start_ok, w_last_node, w_range_bad, w_order_bad;
    logic               w_ready, w_accept, w_good, w_ovf, w_clr;
    logic               w_full, w_dup, w_we;
    logic [ADDR_W-1:0]  w_adj_ptr, w_addr;
    logic [REC_W-1:0]   w_rec, w_data;

    assign w_start_ok  = (r_state == S_IDLE) && start;
    assign w_last_node = (r_cur == r_n);
    assign w_adj_ptr   = ADJ_BASE + ADDR_W'(r_cur) - 13'd1;
    assign w_range_bad = (edge_src == 8'd0) || (edge_src > r_n) || (edge_dst > r_n);
    assign w_order_bad = (edge_src < r_cur);
    // Range violators are taken and dropped even when src is ahead of cur,
    // otherwise an out-of-range src would stall the stream forever.
    assign w_ready     = (r_state == S_COLLECT) && ((edge_src <= r_cur) || w_range_bad);
    assign w_accept    = edge_valid && w_ready;
    assign w_good      = w_accept && !w_range_bad && !w_order_bad;
    assign w_ovf       = w_good && w_full && !w_dup;
    assign w_clr       = w_start_ok || ((r_state == S_WR_IDX) && !w_last_node);

    adj_packer u_packer (
        .clock    (clock),
        .reset    (reset),
        .i_clr    (w_clr),
        .i_push   (w_good),
        .i_dst    (edge_dst),
        .i_wt     (edge_wt),
        .o_record (w_rec),
        .o_full   (w_full),
        .o_dup    (w_dup)
    );

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_next = (num_nodes == 8'd0) ? S_WR_HDR : S_COLLECT;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_COLLECT: begin
                if (w_accept && edge_last) begin
                    w_state_next = S_WR_ADJ;
                end else if (edge_valid && !w_ready) begin
                    w_state_next = S_WR_ADJ;
                end else begin
                    w_state_next = S_COLLECT;
                end
            end
            S_WR_ADJ: w_state_next = S_WR_IDX;
            S_FILL:   w_state_next = S_WR_IDX;
            S_WR_IDX: begin
                if (w_last_node) begin
                    w_state_next = S_WR_HDR;
                end else if (r_tail) begin
                    w_state_next = S_FILL;
                end else begin
                    w_state_next = S_COLLECT;
                end
            end
            S_WR_HDR: w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // FSM output logic: memory write selected by state
    always_comb begin
        w_we   = 1'b0;
        w_addr = '0;
        w_data = '0;
        case (r_state)
            S_WR_ADJ, S_FILL: begin
                w_we   = 1'b1;
                w_addr = w_adj_ptr;
                w_data = w_rec;
            end
            S_WR_IDX: begin
                w_we   = 1'b1;
                w_addr = ADDR_W'(r_cur);
                w_data[NEXT_HI:NEXT_LO] = w_last_node ? 8'd0 : (r_cur + 8'd1);
                w_data[PTR_HI:0]        = w_adj_ptr;
            end
            S_WR_HDR: begin
                w_we   = 1'b1;
                w_addr = HDR_ADDR;
                w_data[NODE_W-1:0] = r_n;
            end
            default: begin
                w_we   = 1'b0;
                w_addr = '0;
                w_data = '0;
            end
        endcase
    end

    // Load context: node cursor, node count, tail flag and sticky errors
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_n       <= '0;
            r_cur     <= '0;
            r_tail    <= 1'b0;
            r_err_ovf <= 1'b0;
            r_err_ord <= 1'b0;
            r_err_rng <= 1'b0;
        end else if (w_start_ok) begin
            r_n       <= num_nodes;
            r_cur     <= 8'd1;
            r_tail    <= 1'b0;
            r_err_ovf <= 1'b0;
            r_err_ord <= 1'b0;
            r_err_rng <= 1'b0;
        end else begin
            if ((r_state == S_WR_IDX) && !w_last_node) begin
                r_cur <= r_cur + 8'd1;
            end
            // A dropped last beat still ends the stream
            if (w_accept && edge_last) begin
                r_tail <= 1'b1;
            end
            if (w_accept && w_range_bad) begin
                r_err_rng <= 1'b1;
            end
            if (w_accept && !w_range_bad && w_order_bad) begin
                r_err_ord <= 1'b1;
            end
            if (w_ovf) begin
                r_err_ovf <= 1'b1;
            end
        end
    end

    // Registered write port and status; busy drops as done rises
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_gmwe  <= 1'b0;
            r_gmwar <= '0;
            r_gmwdr <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_gmwe  <= w_we;
            r_gmwar <= w_addr;
            r_gmwdr <= w_data;
            r_busy  <= (w_state_next != S_IDLE);
            r_done  <= (r_state == S_DONE);
        end
    end

    assign edge_ready   = w_ready;
    assign GMWE         = r_gmwe;
    assign GMWAR        = r_gmwar;
    assign GMWDR        = r_gmwdr;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err_overflow = r_err_ovf;
    assign err_order    = r_err_ord;
    assign err_range    = r_err_rng;

endmodule
